// File: rtl/mul_sequencer.sv
// Sequential signed 8x8 multiply controller. It fetches two operands from data
// memory, runs a shift-add multiply one multiplier bit per cycle, and writes the
// 16-bit product back little-endian. It drives the memory port only while busy.
module mul_sequencer #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned OPA_ADDR  = 0,
    parameter int unsigned OPB_ADDR  = 1,
    parameter int unsigned PROD_ADDR = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
);

    localparam logic [ADDR_W-1:0] OpaAddr    = ADDR_W'(OPA_ADDR);
    localparam logic [ADDR_W-1:0] OpbAddr    = ADDR_W'(OPB_ADDR);
    localparam logic [ADDR_W-1:0] ProdLoAddr = ADDR_W'(PROD_ADDR);
    // High byte address wraps modulo 2^ADDR_W.
    localparam logic [ADDR_W-1:0] ProdHiAddr = ADDR_W'(PROD_ADDR + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLdA,
        StLdB,
        StMul,
        StWrLo,
        StWrHi,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic        start_q;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [2:0]  count_q, count_d;

    logic [15:0] mcand_ext;
    logic [15:0] addend;
    logic        trigger;

    assign mcand_ext = {{8{mcand_q[7]}}, mcand_q};
    assign addend    = mcand_ext << count_q;
    assign trigger   = start_q && !start;

    // State and datapath registers; start is sampled every cycle for edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            start_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

    // Next-state, datapath update and Moore outputs decoded from the state.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        count_d     = count_q;
        busy        = 1'b0;
        done        = 1'b0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;

        unique case (state_q)
            StIdle: begin
                if (trigger) state_d = StLdA;
            end
            StLdA: begin
                busy     = 1'b1;
                mem_addr = OpaAddr;
                mcand_d  = mem_rd_data;
                state_d  = StLdB;
            end
            StLdB: begin
                busy     = 1'b1;
                mem_addr = OpbAddr;
                mplier_d = mem_rd_data;
                acc_d    = '0;
                count_d  = '0;
                state_d  = StMul;
            end
            StMul: begin
                busy = 1'b1;
                if (mplier_q[count_q]) begin
                    // The multiplier sign bit has weight -128, so it subtracts.
                    if (count_q == 3'd7) acc_d = acc_q - addend;
                    else                 acc_d = acc_q + addend;
                end
                count_d = count_q + 3'd1;
                if (count_q == 3'd7) state_d = StWrLo;
            end
            StWrLo: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_addr    = ProdLoAddr;
                mem_wr_data = acc_q[7:0];
                state_d     = StWrHi;
            end
            StWrHi: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_addr    = ProdHiAddr;
                mem_wr_data = acc_q[15:8];
                state_d     = StDone;
            end
            StDone: begin
                done = 1'b1;
                if (start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed testbench for mul_sequencer with a simple combinational-read memory.
module tb_mul_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       done;
    logic       busy;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] mem [256];
    logic       poke_en;
    logic [7:0] poke_addr;
    logic [7:0] poke_data;
    int         wr_count = 0;

    int n_checks = 0;
    int n_fail   = 0;

    mul_sequencer #(
        .ADDR_W   (8),
        .OPA_ADDR (0),
        .OPB_ADDR (1),
        .PROD_ADDR(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_data(mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    // Memory write port shared by the DUT and bench pokes; counts DUT writes.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_count      <= wr_count + 1;
        end
        if (poke_en) mem[poke_addr] <= poke_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] addr, input logic [7:0] data);
        poke_en   = 1'b1;
        poke_addr = addr;
        poke_data = data;
        tick();
        poke_en = 1'b0;
    endtask

    // Start high for one sampled cycle, then low: trigger sampled at the next edge.
    task automatic trigger();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // edges = clock edges already taken since the trigger was set up.
    task automatic wait_done(input int edges_in, output int lat);
        int edges = edges_in;
        while (!done && edges < 40) begin
            tick();
            edges++;
            if (edges == 1) check_eq("busy_in_lda", busy, 1);
        end
        if (!done) check_eq("done_timeout", 0, 1);
        lat = edges - 1;
    endtask

    task automatic finish_op(input string tag, input int wc0, input int lat,
                             input logic [15:0] prod);
        check_eq({tag, "_latency"}, lat, 12);
        check_eq({tag, "_busy_at_done"}, busy, 0);
        check_eq({tag, "_wr_count"}, wr_count - wc0, 2);
        check_eq({tag, "_lo"}, mem[2], prod[7:0]);
        check_eq({tag, "_hi"}, mem[3], prod[15:8]);
        start = 1'b1;
        tick();
        check_eq({tag, "_done_drop"}, done, 0);
        check_eq({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] prod);
        int lat;
        int wc0;
        poke(8'd0, a);
        poke(8'd1, b);
        poke(8'd2, 8'hAA);
        poke(8'd3, 8'hAA);
        wc0 = wr_count;
        trigger();
        wait_done(0, lat);
        finish_op(tag, wc0, lat, prod);
    endtask

    initial begin
        int lat;
        int wc0;
        reset     = 1'b0;
        start     = 1'b1;
        poke_en   = 1'b0;
        poke_addr = '0;
        poke_data = '0;
        tick();
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wr_en", mem_wr_en, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wr_data", mem_wr_data, 0);
        reset = 1'b1;
        tick();

        run_op("p2xm4", 8'd2, 8'hFC, 16'hFFF8);
        run_op("m128sq", 8'h80, 8'h80, 16'h4000);
        run_op("p127xm128", 8'd127, 8'h80, 16'hC080);
        run_op("m128xp127", 8'h80, 8'd127, 16'hC080);
        run_op("zero", 8'd0, 8'h55, 16'h0000);
        run_op("m1sq", 8'hFF, 8'hFF, 16'h0001);

        // Reset during MUL cycle 4, with start held low through release.
        poke(8'd0, 8'd3);
        poke(8'd1, 8'd5);
        poke(8'd2, 8'hAA);
        poke(8'd3, 8'hAA);
        trigger();
        repeat (7) tick();
        check_eq("mid_busy", busy, 1);
        reset = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_wr_en", mem_wr_en, 0);
        check_eq("arst_addr", mem_addr, 0);
        tick();
        reset = 1'b1;
        repeat (5) tick();
        check_eq("held_low_no_trig", busy, 0);
        check_eq("arst_lo_kept", mem[2], 8'hAA);
        check_eq("arst_hi_kept", mem[3], 8'hAA);
        run_op("after_rst", 8'd3, 8'd5, 16'h000F);

        // Start pulses and operand change during MUL are ignored.
        poke(8'd0, 8'd6);
        poke(8'd1, 8'hF9);
        poke(8'd2, 8'hAA);
        poke(8'd3, 8'hAA);
        wc0 = wr_count;
        trigger();
        tick();
        check_eq("pulse_busy_lda", busy, 1);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        poke(8'd1, 8'h11);
        wait_done(7, lat);
        finish_op("pulse", wc0, lat, 16'hFFD6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
